uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one UART transmitter (uart_tx, DBIT-wide byte interface, start/done-tick handshake) between NREQ byte producers.
- Selects a requester, latches its byte, issues a one-cycle start to the transmitter, then waits for the transmitter's done tick before granting again.
- Sits between the system-side producers (command responder, debug logger, etc.) and the single UART TX line.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DBIT, 8, data bits per UART frame; matches transmitter DBIT
- TO_CYCLES, 0, SEND-state watchdog in clk cycles; 0 disables the watchdog

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester byte-valid, level; held until ack
- din  in  NREQ*DBIT  packed bytes; requester i at din[i*DBIT +: DBIT]
- ack  out  NREQ  one-cycle pulse; byte of requester i was latched
- tx_start  out  1  one-cycle start pulse to transmitter
- tx_din  out  DBIT  latched byte to transmitter, stable from tx_start until next grant
- tx_done_tick  in  1  transmitter frame-complete pulse
- busy  out  1  high in START and SEND states
- grant_id  out  clog2(NREQ) (min 1)  index of current/last granted requester
- timeout  out  1  one-cycle pulse when the watchdog expires

Behaviour:
- Reset values: state IDLE; ack=0, tx_start=0, tx_din=0, busy=0, grant_id=0, timeout=0; rr pointer last=NREQ-1, so requester 0 has top priority first; watchdog counter=0.
- All outputs are registered.
- FSM states: IDLE, START, SEND.
- IDLE:
  - If req!=0, winner = first set bit searching last+1, last+2, ... mod NREQ.
  - Next cycle: state=START, tx_din=din[winner], grant_id=winner, ack[winner]=1, tx_start=1, busy=1.
  - Latency: req sampled in cycle n -> tx_start/ack visible in cycle n+1.
- START: lasts exactly one cycle.
  - Next cycle: state=SEND, tx_start=0, ack=0, watchdog counter cleared.
- SEND:
  - Wait for tx_done_tick=1 -> state=IDLE, last=grant_id, busy=0.
  - A new grant can be issued in the IDLE cycle that follows, so back-to-back bytes are separated by at least one IDLE cycle.
- Fairness: the requester just served has the lowest priority on the next arbitration. With all NREQ requesting continuously, the grant order is 0,1,2,3,0,...
- Requester rules:
  - Must keep req and din stable until ack, and must drop req in the cycle after ack if it has no further byte.
  - A req seen in the IDLE cycle after an ack, where the requester wins arbitration, is treated as a new byte.
- tx_done_tick in IDLE or START is ignored. req changes during START/SEND do not affect the byte in flight.
- Watchdog (TO_CYCLES>0):
  - Counter increments each SEND cycle.
  - On reaching TO_CYCLES-1 without tx_done_tick: pulse timeout for 1 cycle, state=IDLE, last=grant_id.
  - If tx_done_tick arrives in the same cycle as expiry, done wins and no timeout pulse is issued.
- Reset asserted mid-operation (any state) forces IDLE on the next edge with all reset values; the byte in flight is abandoned and no ack is repeated.

Optional Feature:
- Macro: UART_ARB_LOCK_EN.
- Enabled:
  - Adds input lock (NREQ bits).
  - If lock[grant_id]=1 when SEND completes (done or timeout), the arbiter enters IDLE in locked mode: only req[grant_id] can win and all other requests are held off.
  - Lock is released when lock[grant_id] is sampled 0 in IDLE; normal round-robin resumes in the same cycle.
  - Allows multi-byte messages without interleaving.
- Disabled: no lock port; pure round-robin per byte.

Test Plan:
- After reset, req=4'b0001, din[7:0]=8'hA5 -> 1 cycle later: tx_start=1, ack=4'b0001, tx_din=8'hA5, grant_id=0; busy stays high until tx_done_tick, then IDLE.
- req=4'b1111 held, tx_done_tick 10 cycles after each start -> ack sequence 0,1,2,3,0; each tx_din equals that requester's byte (8'h10,8'h21,8'h32,8'h43).
- req=4'b0101, last=0 -> grant 2, then 0; then req[0] only -> grant 0 again after one IDLE cycle.
- TO_CYCLES=20, tx_done_tick never asserted -> timeout pulses exactly 20 cycles after START, busy falls, next requester granted.
- Reset asserted in SEND with req=4'b0010 -> next edge all outputs at reset values; after release, requester 1 is regranted with a fresh ack.
- UART_ARB_LOCK_EN: req=4'b0011, lock[1]=1 on requester 1 for 3 bytes -> grants 1,1,1 while requester 0 is held; lock[1]=0 -> grant 0 next.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Round-robin scheduler that shares one UART transmitter between NREQ byte
// producers. Each requester raises req[i] with its byte on din[i*DBIT +: DBIT].
// The arbiter picks a winner, latches the byte, pulses ack[i] and tx_start
// together, then waits in SEND for tx_done_tick before arbitrating again.
//
// Optional build macro: UART_ARB_LOCK_EN
//   When defined, adds input `lock`. If lock[grant_id] is high when a frame
//   finishes, only the same requester may win until lock[grant_id] is seen
//   low in IDLE, so multi-byte messages are not interleaved.
//
// Parameters:
//   NREQ      number of requesters (2..8)
//   DBIT      data bits per frame
//   TO_CYCLES SEND watchdog length in clk cycles, 0 disables it
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset
//   req           per-requester byte-valid level, held until ack
//   din           packed requester bytes
//   lock          (UART_ARB_LOCK_EN only) per-requester message lock
//   ack           one-cycle pulse, byte of requester i latched
//   tx_start      one-cycle start pulse to the transmitter
//   tx_din        latched byte, stable from tx_start until next grant
//   tx_done_tick  transmitter frame-complete pulse
//   busy          high in START and SEND
//   grant_id      index of current/last granted requester
//   timeout       one-cycle pulse when the watchdog expires
//   o_dbg_state   current FSM state (0 IDLE, 1 START, 2 SEND)
//
// Handshake: req/din are a level-valid request that the arbiter consumes with
// a single-cycle ack; the requester drops req the cycle after ack unless it
// has another byte. tx_start/tx_done_tick form a start/complete pair: one
// tx_start per frame, and the arbiter only listens for tx_done_tick in SEND.
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
   parameter  int NREQ      = 4,
   parameter  int DBIT      = 8,
   parameter  int TO_CYCLES = 0,
   localparam int GW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*DBIT-1:0] din,
`ifdef UART_ARB_LOCK_EN
   input  logic [NREQ-1:0]    lock,
`endif
   output logic [NREQ-1:0]    ack,
   output logic               tx_start,
   output logic [DBIT-1:0]    tx_din,
   input  logic               tx_done_tick,
   output logic               busy,
   output logic [GW-1:0]      grant_id,
   output logic               timeout,
   output logic [1:0]         o_dbg_state
);

   localparam int WW = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_SEND  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [NREQ-1:0]   r_ack;
   logic              r_tx_start;
   logic [DBIT-1:0]   r_tx_din;
   logic              r_busy;
   logic [GW-1:0]     r_grant_id;
   logic              r_timeout;
   logic [GW-1:0]     r_last;
   logic [WW-1:0]     r_wd_cnt;

   logic              w_rr_found;
   logic [GW-1:0]     w_rr_winner;
   logic              w_win_valid;
   logic [GW-1:0]     w_winner;
   logic              w_expire;
   logic              w_send_end;
   logic [NREQ-1:0]   w_ack_nxt;
   logic              w_start_nxt;
   logic              w_busy_nxt;
   logic              w_timeout_nxt;

`ifdef UART_ARB_LOCK_EN
   logic              r_locked;
   logic              w_lock_hold;
`endif

   // Round-robin search starting just after the last served requester.
   always_comb begin
      w_rr_found  = 1'b0;
      w_rr_winner = '0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!w_rr_found && req[(int'(r_last) + k) % NREQ]) begin
            w_rr_found  = 1'b1;
            w_rr_winner = GW'((int'(r_last) + k) % NREQ);
         end
      end
   end

`ifdef UART_ARB_LOCK_EN
   // While locked and the lock is still asserted, only the owner may win.
   assign w_lock_hold = r_locked && lock[r_grant_id];
   assign w_win_valid = w_lock_hold ? req[r_grant_id] : w_rr_found;
   assign w_winner    = w_lock_hold ? r_grant_id      : w_rr_winner;
`else
   assign w_win_valid = w_rr_found;
   assign w_winner    = w_rr_winner;
`endif

   // The timeout pulse is raised on the edge where the counter would reach
   // TO_CYCLES-1, so it appears TO_CYCLES cycles after tx_start. A done tick
   // in the same cycle takes priority.
   assign w_expire   = (TO_CYCLES > 0) && (r_state == S_SEND) && !tx_done_tick &&
                       (int'(r_wd_cnt) + 2 >= TO_CYCLES);
   assign w_send_end = (r_state == S_SEND) && (tx_done_tick || w_expire);

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_win_valid) w_state_nxt = S_START;
         S_START: w_state_nxt = S_SEND;
         S_SEND:  if (tx_done_tick || w_expire) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Next values of the registered outputs
   always_comb begin
      w_ack_nxt     = '0;
      w_start_nxt   = 1'b0;
      w_busy_nxt    = (w_state_nxt != S_IDLE);
      w_timeout_nxt = w_expire;
      if (r_state == S_IDLE && w_win_valid) begin
         w_ack_nxt   = NREQ'(1) << w_winner;
         w_start_nxt = 1'b1;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_ack      <= '0;
         r_tx_start <= 1'b0;
         r_tx_din   <= '0;
         r_busy     <= 1'b0;
         r_grant_id <= '0;
         r_timeout  <= 1'b0;
         r_last     <= GW'(NREQ - 1);
         r_wd_cnt   <= '0;
`ifdef UART_ARB_LOCK_EN
         r_locked   <= 1'b0;
`endif
      end else begin
         r_state    <= w_state_nxt;
         r_ack      <= w_ack_nxt;
         r_tx_start <= w_start_nxt;
         r_busy     <= w_busy_nxt;
         r_timeout  <= w_timeout_nxt;
         if (w_start_nxt) begin
            r_tx_din   <= din[int'(w_winner)*DBIT +: DBIT];
            r_grant_id <= w_winner;
         end
         if (r_state == S_START)
            r_wd_cnt <= '0;
         else if (r_state == S_SEND && TO_CYCLES > 0 && !w_send_end)
            r_wd_cnt <= r_wd_cnt + WW'(1);
         if (w_send_end)
            r_last <= r_grant_id;
`ifdef UART_ARB_LOCK_EN
         if (w_send_end)
            r_locked <= lock[r_grant_id];
         else if (r_state == S_IDLE && r_locked && !lock[r_grant_id])
            r_locked <= 1'b0;
`endif
      end
   end

   assign ack         = r_ack;
   assign tx_start    = r_tx_start;
   assign tx_din      = r_tx_din;
   assign busy        = r_busy;
   assign grant_id    = r_grant_id;
   assign timeout     = r_timeout;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter (NREQ=4, DBIT=8, TO_CYCLES=20).
// A cycle table covers single grants, fairness after a served requester,
// re-request after one IDLE cycle and ignored done ticks. Hand-written
// sequences cover full round-robin, watchdog expiry, done-beats-expiry,
// reset during SEND and (with UART_ARB_LOCK_EN) locked messages.
// Inputs change and outputs are compared on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

   localparam int NREQ = 4;
   localparam int DBIT = 8;
   localparam int TOC  = 20;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NREQ-1:0]      req;
   logic [NREQ*DBIT-1:0] din;
   logic [NREQ-1:0]      lock_in;
   logic [NREQ-1:0]      ack;
   logic                 tx_start;
   logic [DBIT-1:0]      tx_din;
   logic                 tx_done_tick;
   logic                 busy;
   logic [1:0]           grant_id;
   logic                 timeout;
   logic [1:0]           dbg_state;

   int n_checks = 0;
   int n_errors = 0;

   uart_tx_arbiter #(.NREQ(NREQ), .DBIT(DBIT), .TO_CYCLES(TOC)) dut (
      .clk          (clk),
      .reset        (reset),
      .req          (req),
      .din          (din),
`ifdef UART_ARB_LOCK_EN
      .lock         (lock_in),
`endif
      .ack          (ack),
      .tx_start     (tx_start),
      .tx_din       (tx_din),
      .tx_done_tick (tx_done_tick),
      .busy         (busy),
      .grant_id     (grant_id),
      .timeout      (timeout),
      .o_dbg_state  (dbg_state)
   );

   // clock
   always #5 clk = ~clk;

   // global time limit
   initial begin
      #2_000_000;
      $display("FAIL time_limit: simulation still running, required finish");
      $fatal(1, "time limit");
   end

   typedef struct packed {
      logic       rst;
      logic [3:0] req;
      logic       done;
      logic [3:0] e_ack;
      logic       e_start;
      logic       e_busy;
      logic [1:0] e_gid;
      logic [7:0] e_din;
   } vec_t;

   localparam int NV = 18;
   vec_t vec [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      reset = 1'b1; req = '0; tx_done_tick = 1'b0; lock_in = '0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Advance until tx_start is seen, bounded.
   task automatic wait_start(input int max_cyc);
      int k;
      k = 0;
      @(negedge clk);
      while (tx_start !== 1'b1 && k < max_cyc) begin
         @(negedge clk);
         k++;
      end
      check("wait_start", tx_start, 1);
   endtask

   // Finish the frame in flight a few cycles into SEND.
   task automatic serve();
      repeat (3) @(negedge clk);
      tx_done_tick = 1'b1;
      @(negedge clk);
      tx_done_tick = 1'b0;
   endtask

   initial begin
      int exp_g [5];
      logic [7:0] bytes [4];
      exp_g = '{0, 1, 2, 3, 0};
      bytes = '{8'h10, 8'h21, 8'h32, 8'h43};

      //               rst  req  done ack  st  busy gid din
      vec[0]  = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 8'h00};
      vec[1]  = '{1'b0, 4'h1, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 8'h00};
      vec[2]  = '{1'b0, 4'h0, 1'b0, 4'h1, 1'b1, 1'b1, 2'd0, 8'hA5};
      vec[3]  = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 2'd0, 8'hA5};
      vec[4]  = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 1'b1, 2'd0, 8'hA5};
      vec[5]  = '{1'b0, 4'h5, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 8'hA5};
      vec[6]  = '{1'b0, 4'h1, 1'b0, 4'h4, 1'b1, 1'b1, 2'd2, 8'h32};
      vec[7]  = '{1'b0, 4'h1, 1'b1, 4'h0, 1'b0, 1'b1, 2'd2, 8'h32};
      vec[8]  = '{1'b0, 4'h1, 1'b0, 4'h0, 1'b0, 1'b0, 2'd2, 8'h32};
      vec[9]  = '{1'b0, 4'h1, 1'b0, 4'h1, 1'b1, 1'b1, 2'd0, 8'hA5};
      vec[10] = '{1'b0, 4'h1, 1'b1, 4'h0, 1'b0, 1'b1, 2'd0, 8'hA5};
      vec[11] = '{1'b0, 4'h1, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 8'hA5};
      vec[12] = '{1'b0, 4'h0, 1'b1, 4'h1, 1'b1, 1'b1, 2'd0, 8'hA5};
      vec[13] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 2'd0, 8'hA5};
      vec[14] = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 1'b1, 2'd0, 8'hA5};
      vec[15] = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 8'hA5};
      vec[16] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 8'hA5};
      vec[17] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 8'hA5};

      // reset
      reset = 1'b1; req = '0; tx_done_tick = 1'b0; lock_in = '0;
      din = {8'h43, 8'h32, 8'h21, 8'hA5};
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_state", dbg_state, 0);
      check("reset_timeout", timeout, 0);

      // table: single grant, fairness, re-request, ignored done ticks
      for (int i = 0; i < NV; i++) begin
         check($sformatf("v%0d_ack", i),   ack,      vec[i].e_ack);
         check($sformatf("v%0d_start", i), tx_start, vec[i].e_start);
         check($sformatf("v%0d_busy", i),  busy,     vec[i].e_busy);
         check($sformatf("v%0d_gid", i),   grant_id, vec[i].e_gid);
         check($sformatf("v%0d_din", i),   tx_din,   vec[i].e_din);
         check($sformatf("v%0d_to", i),    timeout,  0);
         reset = vec[i].rst; req = vec[i].req; tx_done_tick = vec[i].done;
         @(negedge clk);
      end

      // round robin with all requesters active
      reset_pulse();
      din = {8'h43, 8'h32, 8'h21, 8'h10};
      req = 4'hF;
      for (int g = 0; g < 5; g++) begin
         wait_start(40);
         check($sformatf("rr%0d_ack", g), ack, 32'(1) << exp_g[g]);
         check($sformatf("rr%0d_gid", g), grant_id, exp_g[g]);
         check($sformatf("rr%0d_din", g), tx_din, bytes[exp_g[g]]);
         repeat (9) @(negedge clk);
         tx_done_tick = 1'b1;
         @(negedge clk);
         tx_done_tick = 1'b0;
         check($sformatf("rr%0d_gap_busy", g), busy, 0);
         check($sformatf("rr%0d_gap_start", g), tx_start, 0);
      end
      req = '0;

      // watchdog expiry, then next requester
      reset_pulse();
      req = 4'h3;
      wait_start(40);
      check("wd_first_gid", grant_id, 0);
      for (int k = 1; k <= TOC; k++) begin
         @(negedge clk);
         if (k < TOC) check($sformatf("wd_quiet%0d", k), timeout, 0);
         else begin
            check("wd_pulse", timeout, 1);
            check("wd_busy_low", busy, 0);
         end
      end
      @(negedge clk);
      check("wd_pulse_one_cycle", timeout, 0);
      check("wd_next_start", tx_start, 1);
      check("wd_next_gid", grant_id, 1);
      check("wd_next_ack", ack, 4'h2);
      // done arriving in the expiry cycle suppresses the timeout
      repeat (19) @(negedge clk);
      tx_done_tick = 1'b1;
      @(negedge clk);
      tx_done_tick = 1'b0;
      req = '0;
      check("wd_done_wins_to", timeout, 0);
      check("wd_done_wins_busy", busy, 0);

      // reset while in SEND
      reset_pulse();
      din = {8'h43, 8'h32, 8'h21, 8'h10};
      req = 4'h2;
      wait_start(40);
      check("rst_pre_gid", grant_id, 1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rst_ack", ack, 0);
      check("rst_start", tx_start, 0);
      check("rst_din", tx_din, 0);
      check("rst_busy", busy, 0);
      check("rst_gid", grant_id, 0);
      check("rst_state", dbg_state, 0);
      reset = 1'b0;
      @(negedge clk);
      check("rst_regrant_start", tx_start, 1);
      check("rst_regrant_ack", ack, 4'h2);
      check("rst_regrant_gid", grant_id, 1);
      check("rst_regrant_din", tx_din, 8'h21);
      req = '0;
      serve();

`ifdef UART_ARB_LOCK_EN
      // locked three-byte message from requester 1
      reset_pulse();
      req = 4'h1;
      wait_start(40);
      check("lk_pre_gid", grant_id, 0);
      req = 4'h3; lock_in = 4'h2;
      serve();
      for (int b = 0; b < 3; b++) begin
         wait_start(40);
         check($sformatf("lk%0d_gid", b), grant_id, 1);
         check($sformatf("lk%0d_ack", b), ack, 4'h2);
         serve();
      end
      lock_in = '0;
      wait_start(40);
      check("lk_release_gid", grant_id, 0);
      check("lk_release_ack", ack, 4'h1);
      req = '0;
      serve();
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
